// File: rtl/irq_controller.sv
// Edge-triggered, lowest-index-first interrupt controller with a registered vector held through intack.
// Optional mask register is compiled in when IRQ_MASK_EN is defined.
module irq_controller #(
  parameter int NUM_IRQ = 8,
  parameter int VEC_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               intack,
  input  logic               mask_wr,
  input  logic [7:0]         mask_wdata,
  output logic               int_out,
  output logic [VEC_W-1:0]   vector,
  output logic [7:0]         pending,
  output logic [7:0]         lost
);

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t             state, state_n;
  logic [NUM_IRQ-1:0] irq_prev;
  logic [7:0]         pend_r, lost_r, mask, ev, eligible, clr, pend_n, lost_n;
  logic [2:0]         vec_r, vec_n, top_idx;
  logic               int_r, int_n;

  always_comb begin
    ev = '0;
    for (int i = 0; i < NUM_IRQ; i++) ev[i] = irq_in[i] & ~irq_prev[i];
  end

`ifdef IRQ_MASK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          mask <= 8'h00;
    else if (mask_wr) mask <= mask_wdata;
  end
`else
  logic unused_mask;
  assign mask        = 8'h00;
  assign unused_mask = ^{mask_wr, mask_wdata};
`endif

  assign eligible = pend_r & ~mask;

  // Scan downwards so the lowest set index is the last assignment.
  always_comb begin
    top_idx = '0;
    for (int i = 7; i >= 0; i--) if (eligible[i]) top_idx = 3'(i);
  end

  always_comb begin
    state_n = state;
    int_n   = int_r;
    vec_n   = vec_r;
    clr     = '0;
    case (state)
      S_IDLE: begin
        if (intack) begin
          state_n = S_ACK;
          int_n   = 1'b0;
          if (|eligible) clr[vec_r] = 1'b1;
        end else begin
          int_n = |eligible;
          if (|eligible) vec_n = top_idx;
        end
      end
      S_ACK: begin
        int_n = 1'b0;
        if (!intack) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // A new edge outranks the acknowledge clear of the same bit.
  assign pend_n = (pend_r & ~clr) | ev;
  assign lost_n = lost_r | (ev & pend_r);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_prev <= '0;
      pend_r   <= '0;
      lost_r   <= '0;
      vec_r    <= '0;
      int_r    <= 1'b0;
    end else begin
      irq_prev <= irq_in;
      pend_r   <= pend_n;
      lost_r   <= lost_n;
      vec_r    <= vec_n;
      int_r    <= int_n;
    end
  end

  assign int_out = int_r;
  assign vector  = VEC_W'(vec_r);
  assign pending = pend_r;
  assign lost    = lost_r;

endmodule

// File: tb/tb_irq_controller.sv
// Table-driven self-checking bench for irq_controller with an expected-output queue.
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  irq_in = '0;
  logic        intack = 1'b0;
  logic        mask_wr = 1'b0;
  logic [7:0]  mask_wdata = '0;
  logic        int_out;
  logic [15:0] vector;
  logic [7:0]  pending;
  logic [7:0]  lost;

  int checks = 0;
  int errors = 0;

`ifdef IRQ_MASK_EN
  localparam bit MASK_ON = 1'b1;
`else
  localparam bit MASK_ON = 1'b0;
`endif

  irq_controller #(.NUM_IRQ(8), .VEC_W(16)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .intack(intack),
    .mask_wr(mask_wr), .mask_wdata(mask_wdata),
    .int_out(int_out), .vector(vector), .pending(pending), .lost(lost)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [7:0]  irq;
    logic        ack;
    logic        mwr;
    logic [7:0]  mwd;
    logic        eint;
    logic [15:0] evec;
    logic [7:0]  epend;
    logic [7:0]  elost;
  } vec_t;

  typedef struct {
    int          row;
    logic        eint;
    logic [15:0] evec;
    logic [7:0]  epend;
    logic [7:0]  elost;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];

  function automatic vec_t mk(logic [7:0] irq, logic ack, logic mwr, logic [7:0] mwd,
                              logic eint, logic [15:0] evec, logic [7:0] epend, logic [7:0] elost);
    vec_t v;
    v.irq = irq; v.ack = ack; v.mwr = mwr; v.mwd = mwd;
    v.eint = eint; v.evec = evec; v.epend = epend; v.elost = elost;
    return v;
  endfunction

  task automatic check(string name, int row, logic [15:0] act, logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, req);
    end
  endtask

  initial begin
    // single event on bit 1, held ack
    tbl.push_back(mk(8'h02,0,0,8'h00, 0,16'h0,8'h02,8'h00));
    tbl.push_back(mk(8'h00,0,0,8'h00, 1,16'h1,8'h02,8'h00));
    tbl.push_back(mk(8'h00,1,0,8'h00, 0,16'h1,8'h00,8'h00));
    tbl.push_back(mk(8'h00,1,0,8'h00, 0,16'h1,8'h00,8'h00));
    tbl.push_back(mk(8'h00,1,0,8'h00, 0,16'h1,8'h00,8'h00));
    tbl.push_back(mk(8'h00,0,0,8'h00, 0,16'h1,8'h00,8'h00));
    tbl.push_back(mk(8'h00,0,0,8'h00, 0,16'h1,8'h00,8'h00));
    // priority bit 0 over bit 1
    tbl.push_back(mk(8'h03,0,0,8'h00, 0,16'h1,8'h03,8'h00));
    tbl.push_back(mk(8'h00,0,0,8'h00, 1,16'h0,8'h03,8'h00));
    tbl.push_back(mk(8'h00,1,0,8'h00, 0,16'h0,8'h02,8'h00));
    tbl.push_back(mk(8'h00,0,0,8'h00, 0,16'h0,8'h02,8'h00));
    tbl.push_back(mk(8'h00,0,0,8'h00, 1,16'h1,8'h02,8'h00));
    tbl.push_back(mk(8'h00,1,0,8'h00, 0,16'h1,8'h00,8'h00));
    tbl.push_back(mk(8'h00,0,0,8'h00, 0,16'h1,8'h00,8'h00));
    // two edges on bit 0 before ack
    tbl.push_back(mk(8'h01,0,0,8'h00, 0,16'h1,8'h01,8'h00));
    tbl.push_back(mk(8'h00,0,0,8'h00, 1,16'h0,8'h01,8'h00));
    tbl.push_back(mk(8'h01,0,0,8'h00, 1,16'h0,8'h01,8'h01));
    tbl.push_back(mk(8'h00,0,0,8'h00, 1,16'h0,8'h01,8'h01));
    tbl.push_back(mk(8'h00,1,0,8'h00, 0,16'h0,8'h00,8'h01));
    tbl.push_back(mk(8'h00,0,0,8'h00, 0,16'h0,8'h00,8'h01));
    tbl.push_back(mk(8'h00,0,0,8'h00, 0,16'h0,8'h00,8'h01));
    // edge on bit 2 in its own ack-entry cycle
    tbl.push_back(mk(8'h04,0,0,8'h00, 0,16'h0,8'h04,8'h01));
    tbl.push_back(mk(8'h00,0,0,8'h00, 1,16'h2,8'h04,8'h01));
    tbl.push_back(mk(8'h04,1,0,8'h00, 0,16'h2,8'h04,8'h05));
    tbl.push_back(mk(8'h00,0,0,8'h00, 0,16'h2,8'h04,8'h05));
    tbl.push_back(mk(8'h00,0,0,8'h00, 1,16'h2,8'h04,8'h05));
    tbl.push_back(mk(8'h00,1,0,8'h00, 0,16'h2,8'h00,8'h05));
    tbl.push_back(mk(8'h00,0,0,8'h00, 0,16'h2,8'h00,8'h05));
    // spurious ack
    tbl.push_back(mk(8'h00,1,0,8'h00, 0,16'h2,8'h00,8'h05));
    tbl.push_back(mk(8'h00,0,0,8'h00, 0,16'h2,8'h00,8'h05));
    tbl.push_back(mk(8'h00,0,0,8'h00, 0,16'h2,8'h00,8'h05));
    // mask bit 0, pulse it, unmask
    tbl.push_back(mk(8'h00,0,1,8'h01, 0,16'h2,8'h00,8'h05));
    tbl.push_back(mk(8'h01,0,0,8'h00, 0,16'h2,8'h01,8'h05));
    tbl.push_back(mk(8'h00,0,0,8'h00, !MASK_ON, MASK_ON ? 16'h2 : 16'h0, 8'h01,8'h05));
    tbl.push_back(mk(8'h00,0,0,8'h00, !MASK_ON, MASK_ON ? 16'h2 : 16'h0, 8'h01,8'h05));
    tbl.push_back(mk(8'h00,0,1,8'h00, !MASK_ON, MASK_ON ? 16'h2 : 16'h0, 8'h01,8'h05));
    tbl.push_back(mk(8'h00,0,0,8'h00, 1,16'h0,8'h01,8'h05));
    tbl.push_back(mk(8'h00,1,0,8'h00, 0,16'h0,8'h00,8'h05));
    tbl.push_back(mk(8'h00,0,0,8'h00, 0,16'h0,8'h00,8'h05));

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_int", -1, 16'(int_out), 16'h0);
    check("rst_vec", -1, vector, 16'h0);
    check("rst_pend", -1, 16'(pending), 16'h0);
    check("rst_lost", -1, 16'(lost), 16'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      exp_t e;
      @(negedge clk);
      irq_in = tbl[i].irq; intack = tbl[i].ack;
      mask_wr = tbl[i].mwr; mask_wdata = tbl[i].mwd;
      e.row = i; e.eint = tbl[i].eint; e.evec = tbl[i].evec;
      e.epend = tbl[i].epend; e.elost = tbl[i].elost;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard row %0d: got empty queue expected one entry", i);
      end else begin
        e = exp_q.pop_front();
        check("int_out", e.row, 16'(int_out), 16'(e.eint));
        check("vector", e.row, vector, e.evec);
        check("pending", e.row, 16'(pending), 16'(e.epend));
        check("lost", e.row, 16'(lost), 16'(e.elost));
      end
    end

    // reset in the middle of an acknowledge with pending = 0x06
    @(negedge clk);
    intack = 1'b1; mask_wr = 1'b0;
    @(negedge clk);
    irq_in = 8'h06;
    @(posedge clk);
    #1;
    check("ack_pend", 100, 16'(pending), 16'h06);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_int", 101, 16'(int_out), 16'h0);
    check("mid_rst_vec", 101, vector, 16'h0);
    check("mid_rst_pend", 101, 16'(pending), 16'h0);
    check("mid_rst_lost", 101, 16'(lost), 16'h0);
    intack = 1'b0; irq_in = 8'h08;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_pend", 102, 16'(pending), 16'h08);
    check("post_rst_int", 102, 16'(int_out), 16'h0);
    @(posedge clk);
    #1;
    check("post_rst_int", 103, 16'(int_out), 16'h1);
    check("post_rst_vec", 103, vector, 16'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

Edge-triggered, priority-encoded interrupt controller between the system's event sources and the CPU's interrupt interface. It latches rising edges on up to eight request lines (vsync IRQ, 100 ms timer IRQ, spares) and drives the CPU's single `INT` line. It holds a stable vector on the CPU data-in path for the whole `intack` window, then retires that request. It replaces the level-OR and combinational vector mux at top level; the top-level data-in mux selects `vector` while `intack` is high.

## Interface

Parameters:
- `NUM_IRQ`, 8: number of request lines, 1..8. Unused upper bits of 8-bit fields read 0.
- `VEC_W`, 16: vector width. Vector value is zero-extended to this width.

Ports:
- `clk` input 1: system clock, 50 MHz; all state on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `irq_in` input NUM_IRQ: request lines, synchronous to `clk`. Rising edge = one event.
- `intack` input 1: CPU interrupt acknowledge, held high for ≥1 cycle per acknowledge.
- `mask_wr` input 1: mask register write strobe (see Configuration).
- `mask_wdata` input 8: new mask value; bit=1 masks that source.
- `int_out` output 1: registered interrupt request to CPU.
- `vector` output VEC_W: registered index of the serviced/pending source.
- `pending` output 8: registered pending bits, for debug/status.
- `lost` output 8: sticky per-source flag: an edge arrived while that source was already pending.

## Operation

- Edge detect: `irq_prev` registers `irq_in`. An event on bit i is `irq_in[i] & ~irq_prev[i]`.
- Event with `pending[i]`=0 sets `pending[i]`. Event with `pending[i]`=1 sets `lost[i]`. `lost` clears only on reset.
- Eligible set = `pending & ~mask`. Priority: lowest index wins, so IRQ0 (vsync) beats IRQ1 (timer).
- FSM, 2 states:
  - IDLE:
    - Each cycle, `vector` <= index of the highest-priority eligible bit. It holds its old value if the set is empty.
    - `int_out` <= (eligible ≠ 0).
    - On `intack`=1: go to ACK, freeze `vector`, clear `pending[vector]`, `int_out` <= 0.
  - ACK:
    - `vector` frozen, `int_out` held 0.
    - When `intack`=0, return to IDLE.
    - Events still latch during ACK.
- `intack` arriving with an empty eligible set (spurious): still enter ACK. `vector` keeps its last value; no pending bit is cleared.
- Same-cycle event on bit i and clear of bit i at ACK entry: the set wins, so `pending[i]` stays 1 for a new service.
- Masked pending bits remain latched. They become eligible on the cycle after unmasking.
- Reset values: `pending`=0, `lost`=0, `irq_prev`=0, `int_out`=0, `vector`=0, state IDLE, mask=0x00. Reset mid-ACK discards the in-flight acknowledge.
- `irq_prev` resets to 0, so a line already high at reset release produces one event on the first clock.

## Timing

- `irq_in[i]` rises before edge k: `pending[i]`=1 after edge k. `int_out`=1 and `vector` valid after edge k+1. Latency is 2 cycles.
- `vector` is guaranteed valid whenever `int_out`=1 and for the entire time `intack`=1.
- `intack` high at edge a: `int_out`=0 after edge a. With `intack` falling before edge b, the state is IDLE after edge b. If further requests are eligible, `int_out` can re-assert after edge b+1.
- Back-to-back acknowledges: minimum 2 cycles between `intack` deassertion and the next service.

## Configuration

- `IRQ_MASK_EN` defined:
  - Internal 8-bit mask register, reset 0x00.
  - `mask_wr`=1 at an edge loads `mask_wdata`. The new mask affects eligibility from the next cycle.
- Not defined:
  - No mask register; the mask is constant 0.
  - `mask_wr`/`mask_wdata` ports are present but ignored.
  - All pending sources are eligible.

## Test plan

- Single event: pulse `irq_in[1]` for 1 cycle → `int_out`=1 two cycles later with `vector`=0x0001. Hold `intack` 3 cycles → `vector` stable at 0x0001, `int_out`=0, `pending`=0x00.
- Priority: raise `irq_in[1]` and `irq_in[0]` in the same cycle → first service gives `vector`=0x0000. After `intack` drops, `int_out` re-asserts with `vector`=0x0001.
- Lost/collision: two rising edges on bit 0 before any ack → `lost`=0x01, exactly one service. Event on bit 2 in the ACK-entry cycle for bit 2 → `pending[2]` remains 1.
- Mask (`IRQ_MASK_EN`): write mask 0x01, pulse bit 0 → `int_out` stays 0 and `pending`=0x01. Write mask 0x00 → `int_out`=1 with `vector`=0x0000 two cycles later.
- Reset mid-ACK: assert `rst` asynchronously while `intack`=1 and `pending`=0x06 → all outputs 0 immediately, state IDLE. After release, a new event on bit 3 gives `vector`=0x0003.
- Spurious ack: `intack` pulse with `pending`=0 → `int_out` stays 0, `vector` unchanged, `pending` unchanged.
